// File: rtl/inst_sram_fetch_pkg.sv
// Shared constants for the instruction-fetch SRAM stage.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM encodings, reset level, SRAM control levels, default wait states.
package inst_sram_fetch_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } fetch_state_t;

  // rst is active-low
  localparam logic RST_ACTIVE = 1'b0;

  // Active-low SRAM strobes
  localparam logic SRAM_CTRL_ACTIVE   = 1'b0;
  localparam logic SRAM_CTRL_INACTIVE = 1'b1;

  localparam int DEFAULT_WAIT_STATES = 2;
  localparam int CNT_W               = 4;   // holds 0..15 wait states

endpackage

// File: rtl/inst_sram_fetch.sv
// Instruction fetch stage: ROM-style core port onto asynchronous SRAM, with a one-word fetch buffer.
// Latency: hit 0 cycles; miss stalls WAIT_STATES+2 cycles, data valid in the following cycle.
// Backpressure: stall_req_o held high toward the pipeline while the requested word is not buffered.
// Ports: clk/rst (async active-low); core side rom_ce_i, rom_addr_i, inv_i, rom_data_o, stall_req_o;
//        SRAM side sram_addr_o, sram_data_i, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o.
module inst_sram_fetch
  import inst_sram_fetch_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int SRAM_AW     = 20,
  parameter int DATA_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rom_ce_i,
  input  logic [31:0]        rom_addr_i,
  input  logic               inv_i,
  output logic [DATA_W-1:0]  rom_data_o,
  output logic               stall_req_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  input  logic [DATA_W-1:0]  sram_data_i,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o
);

  fetch_state_t state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic               buf_valid_q, buf_valid_nx;
  logic [SRAM_AW-1:0] buf_addr_q, buf_addr_nx;
  logic [DATA_W-1:0]  buf_data_q, buf_data_nx;
  logic [SRAM_AW-1:0] sram_addr_nx;
  logic               sram_ce_n_nx;
  logic               sram_oe_n_nx;

  logic [SRAM_AW-1:0] wa;
  logic               hit;

  // Byte-offset bits and bits above the SRAM range are deliberately dropped:
  // misaligned fetches read the containing word, high addresses alias.
  assign wa  = rom_addr_i[SRAM_AW+1:2];
  assign hit = buf_valid_q & (buf_addr_q == wa) & ~inv_i;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rom_addr_i[31:SRAM_AW+2], rom_addr_i[1:0]};

  // Read-only port
  assign sram_we_n_o = SRAM_CTRL_INACTIVE;
  assign sram_be_n_o = 4'b0000;

  // State and registered datapath; reset deselects the SRAM immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      sram_addr_o <= '0;
      sram_ce_n_o <= SRAM_CTRL_INACTIVE;
      sram_oe_n_o <= SRAM_CTRL_INACTIVE;
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      buf_valid_q <= buf_valid_nx;
      buf_addr_q  <= buf_addr_nx;
      buf_data_q  <= buf_data_nx;
      sram_addr_o <= sram_addr_nx;
      sram_ce_n_o <= sram_ce_n_nx;
      sram_oe_n_o <= sram_oe_n_nx;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nx     = state_q;
    cnt_nx       = cnt_q;
    buf_valid_nx = buf_valid_q & ~inv_i;
    buf_addr_nx  = buf_addr_q;
    buf_data_nx  = buf_data_q;
    sram_addr_nx = sram_addr_o;
    sram_ce_n_nx = SRAM_CTRL_INACTIVE;
    sram_oe_n_nx = SRAM_CTRL_INACTIVE;

    unique case (state_q)
      IDLE: begin
        // ce_n is always high in IDLE, which gives the SRAM a turnaround
        // cycle between consecutive accesses.
        if (rom_ce_i && !hit) begin
          state_nx     = ACCESS;
          sram_addr_nx = wa;
          sram_ce_n_nx = SRAM_CTRL_ACTIVE;
          sram_oe_n_nx = SRAM_CTRL_ACTIVE;
          cnt_nx       = CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!rom_ce_i) begin
          state_nx = IDLE;
        end else if (wa != sram_addr_o) begin
          // Core redirected mid-access: restart the wait period on the new word.
          sram_addr_nx = wa;
          sram_ce_n_nx = SRAM_CTRL_ACTIVE;
          sram_oe_n_nx = SRAM_CTRL_ACTIVE;
          cnt_nx       = CNT_W'(WAIT_STATES);
        end else if (cnt_q != '0) begin
          sram_ce_n_nx = SRAM_CTRL_ACTIVE;
          sram_oe_n_nx = SRAM_CTRL_ACTIVE;
          cnt_nx       = cnt_q - 1'b1;
        end else begin
          // Capture happens even under inv_i; only the valid bit honours it.
          state_nx     = IDLE;
          buf_data_nx  = sram_data_i;
          buf_addr_nx  = sram_addr_o;
          buf_valid_nx = ~inv_i;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Core-facing outputs
  always_comb begin
    stall_req_o = rom_ce_i & ~hit;
    rom_data_o  = (rom_ce_i && hit) ? buf_data_q : '0;
  end

endmodule

// File: tb/tb_inst_sram_fetch.sv
// Directed bench for inst_sram_fetch with a behavioural asynchronous SRAM.
module tb_inst_sram_fetch;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic        inv_i;
  logic [31:0] rom_data_o;
  logic        stall_req_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_data_i;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  logic [31:0] mem [64];

  int pass_cnt  = 0;
  int total_cnt = 0;

  inst_sram_fetch #(.WAIT_STATES(2), .SRAM_AW(20), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .inv_i       (inv_i),
    .rom_data_o  (rom_data_o),
    .stall_req_o (stall_req_o),
    .sram_addr_o (sram_addr_o),
    .sram_data_i (sram_data_i),
    .sram_ce_n_o (sram_ce_n_o),
    .sram_oe_n_o (sram_oe_n_o),
    .sram_we_n_o (sram_we_n_o),
    .sram_be_n_o (sram_be_n_o)
  );

  // Asynchronous SRAM: drives the addressed word only while selected.
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[5:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0000_0010;
    inv_i      = 1'b0;
    step();
    step();
    #1;
    total_cnt++; if (stall_req_o !== 1'b1) $display("FAIL reset_stall got %b exp 1", stall_req_o); else pass_cnt++;
    total_cnt++; if (rom_data_o !== 32'h0) $display("FAIL reset_data got %h exp 0", rom_data_o); else pass_cnt++;
    total_cnt++; if ({sram_ce_n_o, sram_oe_n_o} !== 2'b11) $display("FAIL reset_ce_oe got %b exp 11", {sram_ce_n_o, sram_oe_n_o}); else pass_cnt++;
    total_cnt++; if (sram_addr_o !== 20'h0) $display("FAIL reset_addr got %h exp 0", sram_addr_o); else pass_cnt++;
    total_cnt++; if ({sram_we_n_o, sram_be_n_o} !== 5'b1_0000) $display("FAIL reset_we_be got %b exp 10000", {sram_we_n_o, sram_be_n_o}); else pass_cnt++;
    step();
    rst = 1'b1;
  endtask

  // First cycle after reset release is the detect cycle of a miss on word 4.
  task automatic test_miss();
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (stall_req_o !== 1'b1) $display("FAIL miss_stall c%0d got %b exp 1", i, stall_req_o); else pass_cnt++;
      total_cnt++; if (sram_ce_n_o !== (i == 0) || sram_oe_n_o !== (i == 0))
        $display("FAIL miss_ce_oe c%0d got %b%b exp %b", i, sram_ce_n_o, sram_oe_n_o, i == 0); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (sram_addr_o !== 20'd4) $display("FAIL miss_addr c%0d got %h exp 4", i, sram_addr_o); else pass_cnt++;
      end
      step();
    end
    #1;
    total_cnt++; if (stall_req_o !== 1'b0) $display("FAIL miss_done_stall got %b exp 0", stall_req_o); else pass_cnt++;
    total_cnt++; if (rom_data_o !== 32'h3401_1100) $display("FAIL miss_data got %h exp 34011100", rom_data_o); else pass_cnt++;
  endtask

  task automatic test_hit();
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      total_cnt++; if (stall_req_o !== 1'b0 || sram_ce_n_o !== 1'b1 || rom_data_o !== 32'h3401_1100)
        $display("FAIL hit c%0d got stall=%b ce_n=%b data=%h exp 0 1 34011100", i, stall_req_o, sram_ce_n_o, rom_data_o); else pass_cnt++;
    end
    // Misaligned and aliased addresses select the same word.
    step();
    rom_addr_i = 32'h0000_0013;
    #1;
    total_cnt++; if (stall_req_o !== 1'b0 || rom_data_o !== 32'h3401_1100)
      $display("FAIL hit_misaligned got stall=%b data=%h exp 0 34011100", stall_req_o, rom_data_o); else pass_cnt++;
    rom_addr_i = 32'h0040_0010;
    #1;
    total_cnt++; if (stall_req_o !== 1'b0 || rom_data_o !== 32'h3401_1100)
      $display("FAIL hit_alias got stall=%b data=%h exp 0 34011100", stall_req_o, rom_data_o); else pass_cnt++;
    rom_ce_i = 1'b0;
    #1;
    total_cnt++; if (stall_req_o !== 1'b0 || rom_data_o !== 32'h0)
      $display("FAIL ce_low got stall=%b data=%h exp 0 0", stall_req_o, rom_data_o); else pass_cnt++;
    step();
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0000_0010;
  endtask

  task automatic test_back_to_back();
    step();
    rom_addr_i = 32'h0000_0014;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (stall_req_o !== 1'b1) $display("FAIL seq_stall c%0d got %b exp 1", i, stall_req_o); else pass_cnt++;
      total_cnt++; if (sram_ce_n_o !== (i == 0)) $display("FAIL seq_ce c%0d got %b exp %b", i, sram_ce_n_o, i == 0); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (stall_req_o !== 1'b0 || rom_data_o !== 32'h3402_0020)
      $display("FAIL seq_data got stall=%b data=%h exp 0 34020020", stall_req_o, rom_data_o); else pass_cnt++;
  endtask

  task automatic test_invalidate();
    step();
    mem[5] = 32'hFFFF_0000;
    inv_i  = 1'b1;
    #1;
    total_cnt++; if (stall_req_o !== 1'b1 || rom_data_o !== 32'h0)
      $display("FAIL inv_same_cycle got stall=%b data=%h exp 1 0", stall_req_o, rom_data_o); else pass_cnt++;
    step();
    inv_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (stall_req_o !== 1'b1 || sram_ce_n_o !== 1'b0)
        $display("FAIL inv_access c%0d got stall=%b ce_n=%b exp 1 0", i, stall_req_o, sram_ce_n_o); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (stall_req_o !== 1'b0 || rom_data_o !== 32'hFFFF_0000)
      $display("FAIL inv_refetch got stall=%b data=%h exp 0 ffff0000", stall_req_o, rom_data_o); else pass_cnt++;
  endtask

  task automatic test_addr_change();
    step();
    rom_addr_i = 32'h0000_0020;
    step();
    #1;
    total_cnt++; if (sram_addr_o !== 20'd8) $display("FAIL chg_first_addr got %h exp 8", sram_addr_o); else pass_cnt++;
    step();
    rom_addr_i = 32'h0000_0024;
    #1;
    total_cnt++; if (stall_req_o !== 1'b1) $display("FAIL chg_stall got %b exp 1", stall_req_o); else pass_cnt++;
    // Restart: three full access cycles on word 9.
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      total_cnt++; if (sram_addr_o !== 20'd9 || stall_req_o !== 1'b1 || sram_ce_n_o !== 1'b0)
        $display("FAIL chg_restart c%0d got addr=%h stall=%b ce_n=%b exp 9 1 0", i, sram_addr_o, stall_req_o, sram_ce_n_o); else pass_cnt++;
    end
    step();
    #1;
    total_cnt++; if (stall_req_o !== 1'b0 || rom_data_o !== 32'h2222_9999)
      $display("FAIL chg_data got stall=%b data=%h exp 0 22229999", stall_req_o, rom_data_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    step();
    rom_addr_i = 32'h0000_0030;
    step();
    step();
    #1;
    total_cnt++; if (sram_ce_n_o !== 1'b0) $display("FAIL rstmid_pre_ce got %b exp 0", sram_ce_n_o); else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    total_cnt++; if ({sram_ce_n_o, sram_oe_n_o} !== 2'b11) $display("FAIL rstmid_async_ce_oe got %b exp 11", {sram_ce_n_o, sram_oe_n_o}); else pass_cnt++;
    // Previously buffered word 9 must now miss.
    rom_addr_i = 32'h0000_0024;
    #1;
    total_cnt++; if (stall_req_o !== 1'b1 || rom_data_o !== 32'h0)
      $display("FAIL rstmid_buf_cleared got stall=%b data=%h exp 1 0", stall_req_o, rom_data_o); else pass_cnt++;
    rom_addr_i = 32'h0000_0030;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (stall_req_o !== 1'b1) $display("FAIL rstmid_refetch_stall c%0d got %b exp 1", i, stall_req_o); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (stall_req_o !== 1'b0 || rom_data_o !== 32'h5555_CCCC)
      $display("FAIL rstmid_refetch_data got stall=%b data=%h exp 0 5555cccc", stall_req_o, rom_data_o); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[4]  = 32'h3401_1100;
    mem[5]  = 32'h3402_0020;
    mem[8]  = 32'h1111_8888;
    mem[9]  = 32'h2222_9999;
    mem[12] = 32'h5555_CCCC;

    test_reset();
    test_miss();
    test_hit();
    test_back_to_back();
    test_invalidate();
    test_addr_change();
    test_reset_mid_access();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
